// File: rtl/onehot_strobe_decoder_pkg.sv
// rtl/onehot_strobe_decoder_pkg.sv - widths, FSM state type and one-hot decode helper for onehot_strobe_decoder
package onehot_strobe_pkg;

    localparam int POS_W  = 3;
    localparam int HOLD_W = 4;
    localparam int DATA_W = 2 ** POS_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    function automatic logic [DATA_W-1:0] onehot_decode(input logic [POS_W-1:0] pos);
        logic [DATA_W-1:0] v;
        v      = '0;
        v[pos] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/onehot_strobe_decoder_if.sv
// rtl/onehot_strobe_decoder_if.sv - command handshake and strobe bus of onehot_strobe_decoder
interface onehot_strobe_decoder_if;
    import onehot_strobe_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [POS_W-1:0]  in_pos;
    logic [HOLD_W-1:0] in_hold;
    logic [DATA_W-1:0] data;
    logic              active;
    logic              done;

    modport master (
        output in_valid,
        output in_pos,
        output in_hold,
        input  in_ready,
        input  data,
        input  active,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_pos,
        input  in_hold,
        output in_ready,
        output data,
        output active,
        output done
    );

endinterface

// File: rtl/onehot_strobe_decoder_counter.sv
// rtl/onehot_strobe_decoder_counter.sv - strobe_hold_counter: loadable down-counter, zero hold loads as one
module strobe_hold_counter #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [HOLD_W-1:0] hold_i,
    output logic [HOLD_W-1:0] value_o,
    output logic              last_o
);

    logic [HOLD_W-1:0] value_q;
    logic [HOLD_W-1:0] value_d;

    // Saturates at zero so an idle block never wraps back into a count.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = (hold_i == '0) ? HOLD_W'(1) : hold_i;
        end else if (value_q != '0) begin
            value_d = value_q - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign last_o  = (value_q == HOLD_W'(1));

endmodule

// File: rtl/onehot_strobe_decoder.sv
// rtl/onehot_strobe_decoder.sv - registered one-hot strobe generator; ONEHOT_STROBE_GAP_EN inserts a zero cycle between strobes
module onehot_strobe_decoder
    import onehot_strobe_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    onehot_strobe_decoder_if.slave  bus
);

    state_e            state_q;
    logic [DATA_W-1:0] data_q;
    logic              active_q;
    logic              done_q;

    logic              in_ready;
    logic              accept;
    logic [HOLD_W-1:0] cnt_value;
    logic              cnt_last;
    logic [DATA_W-1:0] pos_onehot;
    logic              hold_is_one;

    strobe_hold_counter #(
        .HOLD_W (HOLD_W)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .hold_i  (bus.in_hold),
        .value_o (cnt_value),
        .last_o  (cnt_last)
    );

    // Ready depends only on state, counter and reset so no path exists from in_valid.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            ST_IDLE:  in_ready = 1'b1;
`ifdef ONEHOT_STROBE_GAP_EN
            ST_DRIVE: in_ready = 1'b0;
            ST_GAP:   in_ready = 1'b1;
`else
            ST_DRIVE: in_ready = cnt_last;
            ST_GAP:   in_ready = 1'b0;
`endif
            default:  in_ready = 1'b0;
        endcase
        if (rst) begin
            in_ready = 1'b0;
        end
    end

    assign accept      = bus.in_valid && in_ready;
    assign pos_onehot  = onehot_decode(bus.in_pos);
    assign hold_is_one = (bus.in_hold == HOLD_W'(0)) || (bus.in_hold == HOLD_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                // Direct overwrite keeps back-to-back strobes strictly one-hot.
                state_q  <= ST_DRIVE;
                data_q   <= pos_onehot;
                active_q <= 1'b1;
                done_q   <= hold_is_one;
            end else begin
                unique case (state_q)
                    ST_DRIVE: begin
                        if (cnt_last) begin
                            data_q   <= '0;
                            active_q <= 1'b0;
`ifdef ONEHOT_STROBE_GAP_EN
                            state_q  <= ST_GAP;
`else
                            state_q  <= ST_IDLE;
`endif
                        end else begin
                            done_q <= (cnt_value == HOLD_W'(2));
                        end
                    end
                    ST_GAP:  state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.data     = data_q;
    assign bus.active   = active_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// tb/tb_onehot_strobe_decoder.sv - directed vector table plus random loopback for onehot_strobe_decoder
module tb_onehot_strobe_decoder;

    logic clk;
    logic rst;

    onehot_strobe_decoder_if bus();

    onehot_strobe_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       v;
        logic [2:0] p;
        logic [3:0] h;
        logic       rdy;
        logic [7:0] d;
        logic       dn;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       dn;
    } exp_t;

`ifdef ONEHOT_STROBE_GAP_EN
    localparam logic LAST_RDY = 1'b0;
    localparam bit   GAP_EN   = 1'b1;
`else
    localparam logic LAST_RDY = 1'b1;
    localparam bit   GAP_EN   = 1'b0;
`endif

    exp_t exp_q[$];
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [2:0] enc8to3(input logic [7:0] d);
        logic [2:0] p;
        p = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) p = 3'(i);
        end
        return p;
    endfunction

    task automatic step(input logic r, input logic v, input logic [2:0] p, input logic [3:0] h,
                        input logic exp_rdy, input logic [7:0] exp_d, input logic exp_dn);
        exp_t e;
        @(negedge clk);
        rst          = r;
        bus.in_valid = v;
        bus.in_pos   = p;
        bus.in_hold  = h;
        #1;
        chk("in_ready", {7'd0, bus.in_ready}, {7'd0, exp_rdy});
        exp_q.push_back('{d: exp_d, dn: exp_dn});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            e = exp_q.pop_front();
            chk("data", bus.data, e.d);
            chk("done", {7'd0, bus.done}, {7'd0, e.dn});
            chk("active", {7'd0, bus.active}, {7'd0, (e.d != 8'd0)});
            chk("popcount", 8'($countones(bus.data)), (e.d != 8'd0) ? 8'd1 : 8'd0);
        end
    endtask

    vec_t tbl[22];

    // Behavioural reference for the random phase.
    int         m_state;
    int         m_cnt;
    logic [7:0] m_data;
    logic       m_done;
    logic [2:0] m_pos;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_pos   = 3'd0;
        bus.in_hold  = 4'd0;

        tbl[0]  = '{1'b1, 1'b1, 3'd2, 4'd3,  1'b0,     8'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 3'd2, 4'd3,  1'b0,     8'h00, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 3'd0, 4'd0,  1'b1,     8'h00, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 3'd5, 4'd3,  1'b1,     8'h20, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 3'd6, 4'd9,  1'b0,     8'h20, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 3'd6, 4'd9,  1'b0,     8'h20, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 3'd0, 4'd0,  LAST_RDY, 8'h00, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 3'd0, 4'd0,  1'b1,     8'h01, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 3'd0, 4'd0,  LAST_RDY, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 3'd7, 4'd2,  1'b1,     8'h80, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 3'd1, 4'd1,  1'b0,     8'h80, 1'b1};
`ifdef ONEHOT_STROBE_GAP_EN
        tbl[11] = '{1'b0, 1'b1, 3'd1, 4'd1,  1'b0,     8'h00, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 3'd1, 4'd1,  1'b1,     8'h02, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 3'd0, 4'd0,  1'b0,     8'h00, 1'b0};
`else
        tbl[11] = '{1'b0, 1'b1, 3'd1, 4'd1,  1'b1,     8'h02, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 3'd0, 4'd0,  1'b1,     8'h00, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 3'd0, 4'd0,  1'b1,     8'h00, 1'b0};
`endif
        tbl[14] = '{1'b0, 1'b0, 3'd0, 4'd0,  1'b1,     8'h00, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 3'd3, 4'd15, 1'b1,     8'h08, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 3'd0, 4'd0,  1'b0,     8'h08, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 3'd0, 4'd0,  1'b0,     8'h08, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 3'd0, 4'd0,  1'b0,     8'h08, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 3'd3, 4'd15, 1'b0,     8'h00, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 3'd0, 4'd0,  1'b1,     8'h00, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 3'd0, 4'd0,  1'b1,     8'h00, 1'b0};

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].p, tbl[i].h, tbl[i].rdy, tbl[i].d, tbl[i].dn);
        end

        // Random stream: state 0=idle, 1=drive, 2=gap; m_cnt is remaining strobe cycles.
        m_state = 0; m_cnt = 0; m_data = 8'h00; m_done = 1'b0; m_pos = 3'd0;
        for (int n = 0; n < 600; n++) begin
            logic       r, v, rdy, acc;
            logic [2:0] p;
            logic [3:0] h;
            int         hh;
            r = (n == 0) || ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 3) != 0);
            p = 3'($urandom_range(0, 7));
            h = 4'($urandom_range(0, 15));
            rdy = !r && ((m_state == 0) || (m_state == 2 && GAP_EN) ||
                         (m_state == 1 && m_cnt == 1 && !GAP_EN));
            acc = v && rdy;
            if (r) begin
                m_state = 0; m_cnt = 0; m_data = 8'h00; m_done = 1'b0;
            end else if (acc) begin
                hh = (h == 4'd0) ? 1 : int'(h);
                m_state = 1; m_cnt = hh; m_data = 8'h01 << p; m_done = (hh == 1); m_pos = p;
            end else if (m_state == 1) begin
                if (m_cnt == 1) begin
                    m_state = GAP_EN ? 2 : 0; m_cnt = 0; m_data = 8'h00; m_done = 1'b0;
                end else begin
                    m_cnt = m_cnt - 1; m_done = (m_cnt == 1);
                end
            end else begin
                m_state = 0; m_data = 8'h00; m_done = 1'b0;
            end
            step(r, v, p, h, rdy, m_data, m_done);
            if (bus.active) begin
                chk("loop_pos", {5'd0, enc8to3(bus.data)}, {5'd0, m_pos});
            end
        end

        step(1'b0, 1'b0, 3'd0, 4'd0, (m_state == 0) || (m_state == 2 && GAP_EN) ||
             (m_state == 1 && m_cnt == 1 && !GAP_EN),
             (m_state == 1 && m_cnt > 1) ? m_data : 8'h00,
             (m_state == 1 && m_cnt == 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
